// File: rtl/playback_pkg.sv
// Shared definitions for the playback sequencer: state encoding and flow-control bytes.
package playback_pkg;

    typedef enum logic [1:0] {
        STATE_PREFILL = 2'd0,
        STATE_PLAY    = 2'd1,
        STATE_PAUSE   = 2'd2
    } state_e;

    localparam logic [7:0] XON_BYTE  = 8'h11;
    localparam logic [7:0] XOFF_BYTE = 8'h13;

endpackage

// File: rtl/playback_ctrl_btn_debounce.sv
// Pushbutton conditioning: 2-FF synchronizer, stability counter, one-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // A new level must be seen for DEBOUNCE_CYC consecutive cycles; any return resets the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/playback_ctrl.sv
// Playback sequencer: prefill/play/pause FSM, DAC mute, XON/XOFF pacing of the host.
// Define PLAYBACK_CTRL_STATS_EN to implement the saturating underrun counter.
module playback_ctrl
    import playback_pkg::*;
#(
    parameter int DEPTH        = 512,
    parameter int PREFILL      = 256,
    parameter int HIGH_WM      = 448,
    parameter int LOW_WM       = 128,
    parameter int DEBOUNCE_CYC = 270000,
    parameter int UNMUTE_DLY   = 64,
    localparam int LEVEL_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               sample_tick,
    input  logic               btn_n,
    output logic               play_en,
    output logic               mute,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [1:0]         state,
    output logic [15:0]        underrun_cnt
);

    localparam logic [1:0] ST_PREFILL = STATE_PREFILL;
    localparam logic [1:0] ST_PLAY    = STATE_PLAY;
    localparam logic [1:0] ST_PAUSE   = STATE_PAUSE;
    localparam int         UW         = $clog2(UNMUTE_DLY + 2);

    logic          press;
    logic          underrun;
    logic [1:0]    next_state;
    logic [UW-1:0] unmute_cnt;
    logic [UW-1:0] unmute_inc;
    logic          host_stopped;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .press (press)
    );

    assign underrun = (state == ST_PLAY) && sample_tick && (fifo_level == '0);

    // A press overrides any level-driven transition; the underrun is still counted below.
    always_comb begin
        next_state = state;
        case (state)
            ST_PREFILL: begin
                if (press)
                    next_state = ST_PAUSE;
                else if (fifo_level >= LEVEL_W'(PREFILL))
                    next_state = ST_PLAY;
            end
            ST_PLAY: begin
                if (press)
                    next_state = ST_PAUSE;
                else if (underrun)
                    next_state = ST_PREFILL;
            end
            ST_PAUSE: begin
                if (press)
                    next_state = ST_PREFILL;
            end
            default: next_state = ST_PREFILL;
        endcase
    end

    assign unmute_inc = (sample_tick && (unmute_cnt < UW'(UNMUTE_DLY))) ? unmute_cnt + 1'b1
                                                                          : unmute_cnt;

    // play_en and mute are derived from next_state so they change together with state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_PREFILL;
            play_en    <= 1'b0;
            mute       <= 1'b1;
            unmute_cnt <= '0;
        end else begin
            state   <= next_state;
            play_en <= (next_state == ST_PLAY);
            if (next_state != ST_PLAY) begin
                unmute_cnt <= '0;
                mute       <= 1'b1;
            end else if (state != ST_PLAY) begin
                unmute_cnt <= '0;
                mute       <= (UNMUTE_DLY != 0);
            end else begin
                unmute_cnt <= unmute_inc;
                mute       <= (unmute_inc < UW'(UNMUTE_DLY));
            end
        end
    end

    // One byte in flight at most; the watermark test only runs while nothing is pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            host_stopped <= 1'b0;
        end else if (tx_valid) begin
            if (tx_ready) begin
                tx_valid     <= 1'b0;
                host_stopped <= ~host_stopped;
            end
        end else if (!host_stopped && (fifo_level >= LEVEL_W'(HIGH_WM))) begin
            tx_valid <= 1'b1;
            tx_data  <= XOFF_BYTE;
        end else if (host_stopped && (fifo_level <= LEVEL_W'(LOW_WM))) begin
            tx_valid <= 1'b1;
            tx_data  <= XON_BYTE;
        end
    end

`ifdef PLAYBACK_CTRL_STATS_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            underrun_q <= 16'h0000;
        else if (underrun && (underrun_q != 16'hFFFF))
            underrun_q <= underrun_q + 16'h0001;
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: doc/playback_ctrl.md
# playback_ctrl

Playback sequencer between the UART receive path, the sample FIFO and the I2S driver, on the 27 MHz system clock. Monitors FIFO fill level, gates FIFO reads, drives the DAC mute line and paces the host with XON/XOFF bytes on the UART transmitter. Handles prefill, underrun recovery and button-driven pause/resume.

## Interface
- DEPTH, 512, FIFO capacity in samples
- PREFILL, 256, level required before playback starts
- HIGH_WM, 448, level at/above which XOFF is sent
- LOW_WM, 128, level at/below which XON is sent; LOW_WM < PREFILL < HIGH_WM <= DEPTH
- DEBOUNCE_CYC, 270000, stable cycles for a button edge (10 ms)
- UNMUTE_DLY, 64, sample ticks in PLAY before mute releases
- LEVEL_W, $clog2(DEPTH+1), level width (derived, not overridden)

Ports:
- clk  in  1  system clock, 27 MHz
- rst_n  in  1  synchronous, active-low reset
- fifo_level  in  LEVEL_W  current FIFO occupancy
- sample_tick  in  1  one-cycle pulse per I2S frame from driver
- btn_n  in  1  raw pushbutton, active-low, asynchronous
- play_en  out  1  FIFO read permission for the driver
- mute  out  1  DAC mute, 1 = muted
- tx_data  out  8  flow-control byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART transmitter accepts byte
- state  out  2  current state, for LEDs
- underrun_cnt  out  16  saturating underrun count

## Operation
- States: PREFILL (0), PLAY (1), PAUSE (2); encoding 3 unused, recovers to PREFILL.
- PREFILL -> PLAY when fifo_level >= PREFILL.
- PLAY -> PREFILL on underrun: sample_tick with fifo_level == 0; increments underrun_cnt (saturates at 0xFFFF).
- PLAY or PREFILL -> PAUSE on button press event.
- PAUSE -> PREFILL on button press event.
- Press and underrun in same cycle: press wins (PAUSE), underrun still counted.
- play_en = 1 only in PLAY.
- mute = 1 outside PLAY; on entry to PLAY, unmute counter clears, counts sample_ticks, mute drops when count reaches UNMUTE_DLY. UNMUTE_DLY = 0: mute drops on first PLAY cycle.
- Button: 2-FF synchronizer, then counter requiring DEBOUNCE_CYC consecutive cycles of a new level to accept it; a press event is a one-cycle pulse on accepted 1->0 transition. Release produces no event.
- Flow control: flag host_stopped (reset 0). If !host_stopped and fifo_level >= HIGH_WM, present XOFF (0x13); if host_stopped and fifo_level <= LOW_WM, present XON (0x11). Flag toggles on tx_valid && tx_ready. At most one byte outstanding; tx_data stable and tx_valid held until accepted, even if level crosses back. Conditions re-evaluated the cycle after acceptance. Watermark logic runs in all states.

## Timing
- Reset values: state = PREFILL, play_en 0, mute 1, tx_valid 0, tx_data 0x00, underrun_cnt 0, host_stopped 0, debounced level 1, counters 0.
- Reset mid-transfer drops tx_valid immediately; no byte retained.
- All outputs registered. State change visible one cycle after the qualifying input cycle; play_en/mute follow in the same cycle as state.
- tx_valid rises one cycle after watermark crossing; next byte earliest two cycles after acceptance.
- Press latency: 2 sync cycles + DEBOUNCE_CYC + 1 cycles from btn_n edge to state change.

## Configuration
- PLAYBACK_CTRL_STATS_EN: defined -> underrun counter implemented as above. Undefined -> counter logic removed, underrun_cnt tied to 0; state behaviour unchanged.

## Structure
- Shared package playback_pkg: state enum, XON_BYTE 8'h11, XOFF_BYTE 8'h13.
- One sub-module: btn_debounce (synchronizer, debounce counter, press pulse), parameter DEBOUNCE_CYC.

## Test plan
Bench params DEPTH=16, PREFILL=8, HIGH_WM=14, LOW_WM=4, DEBOUNCE_CYC=4, UNMUTE_DLY=2.
- Reset, ramp level 0->8 -> PLAY one cycle after level=8, play_en=1, mute=1 until 2nd sample_tick in PLAY, then 0.
- In PLAY, level=0 with sample_tick -> PREFILL next cycle, play_en=0, mute=1, underrun_cnt=1; 0xFFFF + underrun stays 0xFFFF.
- Level to 14, tx_ready=0 for 5 cycles -> tx_valid=1, tx_data=0x13 held; accept, drop level to 4 -> 0x11 presented; no repeat XOFF while level stays 14.
- btn_n low for 3 cycles -> no event; low 8 cycles in PLAY -> PAUSE after 2+4+1 cycles; second press -> PREFILL, then PLAY if level >= 8.
- Press and underrun same cycle -> PAUSE, underrun_cnt incremented.
- rst_n low during pending XOFF -> tx_valid=0 next cycle, all outputs at reset values; build without PLAYBACK_CTRL_STATS_EN -> underrun_cnt always 0.
